echo_unit: RTL and testbench

- Feedback echo stage downstream of the music player and upstream of the codec output path.
- Consumes the mixed 16-bit signed sample and its one-cycle valid pulse.
- Adds an attenuated copy of the output from DEPTH samples earlier, saturates the result, and emits the new sample with its own one-cycle valid pulse.
- Delay storage is a circular buffer in a synchronous-read RAM.

---
 rtl/echo_unit_pkg.sv | 27 ++
 rtl/echo_ram.sv | 28 ++
 rtl/echo_unit.sv | 126 ++++++++++++
 tb/tb_echo_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/echo_unit_pkg.sv
// Shared audio definitions for the echo stage: sample width, saturation
// limits, FSM encodings and the 18-to-16-bit saturating narrowing helper.
package echo_unit_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        MIX  = 2'd2
    } echo_state_t;

    // Clamp an 18-bit signed sum into the 16-bit sample range.
    function automatic logic signed [15:0] sat16(input logic signed [17:0] x);
        if (x > 18'sd32767) begin
            return SAT_MAX;
        end else if (x < -18'sd32768) begin
            return SAT_MIN;
        end else begin
            return x[15:0];
        end
    endfunction

endpackage

// File: rtl/echo_ram.sv
// Simple dual-port delay memory: one write port, one registered read port
// with a single cycle of latency. No reset so it maps onto block RAM.
module echo_ram #(
    parameter int DEPTH_LOG2 = 12,
    parameter int SAMPLE_W   = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [DEPTH_LOG2-1:0]      wr_addr,
    input  logic signed [SAMPLE_W-1:0] wr_data,
    input  logic                       rd_en,
    input  logic [DEPTH_LOG2-1:0]      rd_addr,
    output logic signed [SAMPLE_W-1:0] rd_data
);

    logic signed [SAMPLE_W-1:0] mem [2**DEPTH_LOG2];

    // Write port and registered read port share the one clock.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/echo_unit.sv
// Feedback echo stage: adds an attenuated copy of the output from
// 2**DEPTH_LOG2 samples earlier to each incoming sample, saturating the sum.
// Each accepted sample walks IDLE -> READ -> MIX; the delay line is a
// circular buffer whose tap is read in IDLE and overwritten in MIX.
module echo_unit #(
    parameter int DEPTH_LOG2 = 12,
    parameter int SAMPLE_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [1:0]                 gain_shift,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_out_valid,
    output logic                       overrun
);

    import echo_unit_pkg::*;

    // fill counts up to exactly DEPTH, so it needs one bit more than wr_ptr.
    localparam logic [DEPTH_LOG2:0] FILL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    echo_state_t state, next_state;

    logic [DEPTH_LOG2-1:0]      wr_ptr;
    logic [DEPTH_LOG2:0]        fill;

    logic signed [SAMPLE_W-1:0] in_l;
    logic                       enable_l;
    logic [1:0]                 gain_l;

    logic                       ram_rd_en;
    logic                       ram_we;
    logic signed [SAMPLE_W-1:0] ram_q;

    logic signed [SAMPLE_W-1:0] tap;
    logic signed [SAMPLE_W-1:0] tap_sh;
    logic [2:0]                 shamt;
    logic signed [SAMPLE_W+1:0] sum;
    logic signed [SAMPLE_W-1:0] wet;

    // Delay line; the read issued in IDLE is held on ram_q through MIX.
    echo_ram #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .SAMPLE_W  (SAMPLE_W)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .wr_addr(wr_ptr),
        .wr_data(wet),
        .rd_en  (ram_rd_en),
        .rd_addr(wr_ptr),
        .rd_data(ram_q)
    );

    // Next-state and RAM strobes. Reset forces IDLE asynchronously, which
    // also drops ram_we so an interrupted MIX never writes.
    always_comb begin
        next_state = state;
        ram_rd_en  = 1'b0;
        ram_we     = 1'b0;
        case (state)
            IDLE: begin
                if (sample_valid) begin
                    ram_rd_en  = 1'b1;
                    next_state = READ;
                end
            end
            READ: next_state = MIX;
            MIX: begin
                ram_we     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Wet sample: the tap only counts once every buffer slot has been written.
    always_comb begin
        tap = '0;
        if (fill == FILL_FULL && enable_l) begin
            tap = ram_q;
        end
        shamt  = {1'b0, gain_l} + 3'd1;
        tap_sh = tap >>> shamt;
        sum    = {{2{in_l[SAMPLE_W-1]}}, in_l} + {{2{tap_sh[SAMPLE_W-1]}}, tap_sh};
        wet    = sat16(sum);
    end

    // Control, pointers and outputs, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            fill             <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            state            <= next_state;
            sample_out_valid <= (state == MIX);
            if (state == MIX) begin
                sample_out <= wet;
                wr_ptr     <= wr_ptr + 1'b1;
                if (fill != FILL_FULL) begin
                    fill <= fill + 1'b1;
                end
            end
            if (sample_valid && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    // Capture the accepted sample and its per-sample settings.
    always_ff @(posedge clk) begin
        if (state == IDLE && sample_valid) begin
            in_l     <= sample_in;
            enable_l <= enable;
            gain_l   <= gain_shift;
        end
    end

endmodule

// File: tb/tb_echo_unit.sv
// Directed bench for echo_unit with an 8-sample delay line.
module tb_echo_unit;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [1:0]         gain_shift;
    logic               sample_valid;
    logic signed [15:0] sample_in;
    logic signed [15:0] sample_out;
    logic               sample_out_valid;
    logic               overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic signed [15:0] din;
        logic               en;
        logic [1:0]         gs;
        logic signed [15:0] exp;
        string              tag;
    } vec_t;

    vec_t vecs[$];

    echo_unit #(
        .DEPTH_LOG2(3),
        .SAMPLE_W  (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .gain_shift      (gain_shift),
        .sample_valid    (sample_valid),
        .sample_in       (sample_in),
        .sample_out      (sample_out),
        .sample_out_valid(sample_out_valid),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int din, input logic en, input logic [1:0] gs,
                       input int exp, input string tag);
        vec_t v;
        v.din = 16'(din);
        v.en  = en;
        v.gs  = gs;
        v.exp = 16'(exp);
        v.tag = tag;
        vecs.push_back(v);
    endtask

    // One accepted sample: checks the valid pulse lands two edges after
    // capture, is one cycle wide, and returns the value it carried.
    task automatic send(input logic signed [15:0] s, input logic en,
                        input logic [1:0] gs, input string tag,
                        output logic signed [15:0] got);
        @(negedge clk);
        sample_in    = s;
        enable       = en;
        gain_shift   = gs;
        sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        chk({tag, "_vld_e0"}, int'(sample_out_valid), 0);
        @(negedge clk);
        chk({tag, "_vld_e1"}, int'(sample_out_valid), 0);
        @(negedge clk);
        chk({tag, "_vld_e2"}, int'(sample_out_valid), 1);
        got = sample_out;
        @(negedge clk);
        chk({tag, "_vld_e3"}, int'(sample_out_valid), 0);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic signed [15:0] got;
        int pulses;
        int last_out;

        reset        = 1'b1;
        enable       = 1'b0;
        gain_shift   = 2'd0;
        sample_valid = 1'b0;
        sample_in    = '0;

        // Fill gating: the tap is ignored until 8 samples have been written.
        for (int i = 0; i < 8; i++) add(1000, 1'b1, 2'd0, 1000, "fill");
        // Bypass zeros: fill keeps counting, the buffer is cleared to 0.
        for (int i = 0; i < 8; i++) add(0, 1'b0, 2'd0, 0, "byp0");
        // Impulse and its feedback decay every 8 samples.
        add(1000, 1'b1, 2'd0, 1000, "imp");
        for (int i = 0; i < 7; i++) add(0, 1'b1, 2'd0, 0, "imp_z1");
        add(0, 1'b1, 2'd0, 500, "echo1");
        for (int i = 0; i < 7; i++) add(0, 1'b1, 2'd0, 0, "imp_z2");
        add(0, 1'b1, 2'd0, 250, "echo2");
        // Positive saturation: 30000 + 15000 clamps.
        for (int i = 0; i < 8; i++) add(30000, 1'b0, 2'd0, 30000, "pfill");
        add(30000, 1'b1, 2'd0, 32767, "psat");
        // Negative saturation: -30000 - 15000 clamps.
        for (int i = 0; i < 8; i++) add(-30000, 1'b0, 2'd0, -30000, "nfill");
        add(-30000, 1'b1, 2'd0, -32768, "nsat");
        // Bypass passes the dry sample; re-enabling picks up the tap at once.
        add(1234, 1'b0, 2'd0, 1234, "bypass");
        add(0, 1'b1, 2'd1, -7500, "reen_gs1");
        add(0, 1'b1, 2'd3, -1875, "gs3");
        add(0, 1'b1, 2'd2, -3750, "gs2");

        #12;
        chk("rst_out", int'(sample_out), 0);
        chk("rst_vld", int'(sample_out_valid), 0);
        chk("rst_ovr", int'(overrun), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            send(vecs[i].din, vecs[i].en, vecs[i].gs, $sformatf("%s%0d", vecs[i].tag, i), got);
            chk($sformatf("%s%0d_out", vecs[i].tag, i), int'(got), int'(vecs[i].exp));
        end
        chk("ovr_before", int'(overrun), 0);

        // Back-to-back sample_valid: the second is dropped and flags overrun.
        @(negedge clk);
        sample_in    = 16'sd100;
        enable       = 1'b0;
        gain_shift   = 2'd0;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_in    = 16'sd200;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("ovr_set", int'(overrun), 1);
        pulses   = 0;
        last_out = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sample_out_valid) begin
                pulses++;
                last_out = int'(sample_out);
            end
        end
        chk("ovr_pulses", pulses, 1);
        chk("ovr_out", last_out, 100);
        repeat (20) @(negedge clk);
        chk("ovr_sticky", int'(overrun), 1);

        // Asynchronous reset asserted between edges while in MIX.
        @(negedge clk);
        sample_in    = 16'sd777;
        sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        @(posedge clk);
        chk("pre_rst_out", int'(sample_out), 100);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out", int'(sample_out), 0);
        chk("arst_vld", int'(sample_out_valid), 0);
        chk("arst_ovr", int'(overrun), 0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sample_out_valid) pulses++;
        end
        chk("arst_no_pulse", pulses, 0);
        chk("arst_out_hold", int'(sample_out), 0);

        // Stale RAM must not leak: 8 dry outputs, then the echo resumes.
        for (int i = 0; i < 8; i++) begin
            send(16'sd500, 1'b1, 2'd0, $sformatf("post%0d", i), got);
            chk($sformatf("post%0d_out", i), int'(got), 500);
        end
        send(16'sd0, 1'b1, 2'd0, "post_echo", got);
        chk("post_echo_out", int'(got), 250);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
